gen_counter_bank: RTL and testbench

- Parametrised bank of independent free-running counters, one instance per channel, built with a generate loop.
- Each channel's direction (up/down) and overflow mode (wrap/saturate) are selected at elaboration time.
- Adds per-channel enable, synchronous load, terminal-event pulses and a registered single-channel readout port.
- Sits in the regression tree as the generalised successor of the fixed two-counter generate-if test, and as a reusable stimulus/timebase block for elaboration tests.

---
 rtl/gen_counter_bank.sv | 106 ++++++++++
 tb/tb_gen_counter_bank.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_counter_bank.sv
// Bank of independent counters, one generate instance per channel, with per-channel
// enable, synchronous load, registered terminal-event pulses and a registered readout port.
module gen_counter_bank #(
    parameter int unsigned          WIDTH    = 8,
    parameter int unsigned          CHANNELS = 2,
    parameter logic [CHANNELS-1:0]  DIR_MASK = 2'b10,
    parameter logic [CHANNELS-1:0]  SAT_MASK = '0,
    parameter int unsigned          STEP     = 1,
    parameter int unsigned          INIT     = 0,
    parameter int unsigned          CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          en,
    input  logic                         load,
    input  logic [CH_BITS-1:0]           load_ch,
    input  logic [WIDTH-1:0]             load_val,
    output logic [CHANNELS*WIDTH-1:0]    count,
    output logic [CHANNELS-1:0]          term,
    input  logic                         rd_req,
    input  logic [CH_BITS-1:0]           rd_ch,
    output logic                         rd_valid,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_err
);

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT);
    localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS+1)'(CHANNELS);

    logic [WIDTH-1:0] cnt_q  [CHANNELS];
    logic             term_q [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Extra top bit of raw carries the overflow (up) or borrow (down) flag.
        localparam logic [WIDTH-1:0] LIMIT = DIR_MASK[i] ? '0 : '1;

        logic [WIDTH:0]   raw;
        logic             evt;
        logic [WIDTH-1:0] stepped;
        logic             hit;

        if (DIR_MASK[i]) begin : g_down
            assign raw = {1'b0, cnt_q[i]} - {1'b0, STEP_W};
        end else begin : g_up
            assign raw = {1'b0, cnt_q[i]} + {1'b0, STEP_W};
        end

        assign evt     = raw[WIDTH];
        assign stepped = (SAT_MASK[i] && evt) ? LIMIT : raw[WIDTH-1:0];
        assign hit     = load && (load_ch == CH_BITS'(i));

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q[i]  <= INIT_W;
                term_q[i] <= 1'b0;
            end else if (hit) begin
                cnt_q[i]  <= load_val;
                term_q[i] <= 1'b0;
            end else if (en[i]) begin
                cnt_q[i]  <= stepped;
                term_q[i] <= evt;
            end else begin
                term_q[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        count = '0;
        term  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            count[i*WIDTH +: WIDTH] = cnt_q[i];
            term[i]                 = term_q[i];
        end
    end

    logic [WIDTH-1:0] rd_sel;
    logic             rd_in_range;

    assign rd_in_range = {1'b0, rd_ch} < CH_LIMIT;

    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CH_BITS'(i)) rd_sel = cnt_q[i];
        end
    end

    // Readout samples the pre-update counter values, so it sees the same edge's old state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else if (rd_req) begin
            rd_valid <= 1'b1;
            rd_err   <= ~rd_in_range;
            rd_data  <= rd_in_range ? rd_sel : '0;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gen_counter_bank.sv
// Bench for gen_counter_bank: three differently parameterised instances compared each
// cycle against an integer-arithmetic reference model, plus directed scenario checks.
module tb_gen_counter_bank;

    logic clk;
    logic rst;

    logic [2:0] en_v    [3];
    logic       ld_v    [3];
    logic [1:0] ldch_v  [3];
    logic [7:0] ldval_v [3];
    logic       rq_v    [3];
    logic [1:0] rch_v   [3];

    logic [23:0] count_a;
    logic [2:0]  term_a;
    logic        rdv_a, rde_a;
    logic [7:0]  rdd_a;

    logic [15:0] count_b;
    logic [1:0]  term_b;
    logic        rdv_b, rde_b;
    logic [7:0]  rdd_b;

    logic [7:0]  count_c;
    logic [1:0]  term_c;
    logic        rdv_c, rde_c;
    logic [3:0]  rdd_c;

    int passed = 0;
    int total  = 0;

    // Reference model state, indexed [instance][channel].
    int mc [3][3];
    int mt [3][3];
    int mrv [3];
    int mrd [3];
    int mre [3];

    gen_counter_bank #(
        .WIDTH(8), .CHANNELS(3), .DIR_MASK(3'b010), .SAT_MASK(3'b000), .STEP(1), .INIT(0)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en_v[0]), .load(ld_v[0]), .load_ch(ldch_v[0]),
        .load_val(ldval_v[0]), .count(count_a), .term(term_a), .rd_req(rq_v[0]),
        .rd_ch(rch_v[0]), .rd_valid(rdv_a), .rd_data(rdd_a), .rd_err(rde_a)
    );

    gen_counter_bank #(
        .WIDTH(8), .CHANNELS(2), .DIR_MASK(2'b10), .SAT_MASK(2'b01), .STEP(1), .INIT(0)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en_v[1][1:0]), .load(ld_v[1]), .load_ch(ldch_v[1][0:0]),
        .load_val(ldval_v[1]), .count(count_b), .term(term_b), .rd_req(rq_v[1]),
        .rd_ch(rch_v[1][0:0]), .rd_valid(rdv_b), .rd_data(rdd_b), .rd_err(rde_b)
    );

    gen_counter_bank #(
        .WIDTH(4), .CHANNELS(2), .DIR_MASK(2'b01), .SAT_MASK(2'b10), .STEP(5), .INIT(20)
    ) dut_c (
        .clk(clk), .rst(rst), .en(en_v[2][1:0]), .load(ld_v[2]), .load_ch(ldch_v[2][0:0]),
        .load_val(ldval_v[2][3:0]), .count(count_c), .term(term_c), .rd_req(rq_v[2]),
        .rd_ch(rch_v[2][0:0]), .rd_valid(rdv_c), .rd_data(rdd_c), .rd_err(rde_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int nch(int d);   return (d == 0) ? 3 : 2; endfunction
    function automatic int wid(int d);   return (d == 2) ? 4 : 8; endfunction
    function automatic int chb(int d);   return (d == 0) ? 2 : 1; endfunction
    function automatic int stp(int d);   return (d == 2) ? 5 : 1; endfunction
    function automatic int ini(int d);   return ((d == 2) ? 20 : 0) % (1 << wid(d)); endfunction
    function automatic bit down(int d, int ch); return (d == 2) ? (ch == 0) : (ch == 1); endfunction
    function automatic bit sat(int d, int ch);
        return (d == 1 && ch == 0) || (d == 2 && ch == 1);
    endfunction

    function automatic logic [31:0] dut_cnt(int d, int ch);
        case (d)
            0:       return 32'(count_a[ch*8 +: 8]);
            1:       return 32'(count_b[ch*8 +: 8]);
            default: return 32'(count_c[ch*4 +: 4]);
        endcase
    endfunction

    function automatic logic [31:0] dut_term(int d, int ch);
        case (d)
            0:       return 32'(term_a[ch]);
            1:       return 32'(term_b[ch]);
            default: return 32'(term_c[ch]);
        endcase
    endfunction

    function automatic logic [31:0] dut_rdv(int d);
        case (d) 0: return 32'(rdv_a); 1: return 32'(rdv_b); default: return 32'(rdv_c); endcase
    endfunction
    function automatic logic [31:0] dut_rde(int d);
        case (d) 0: return 32'(rde_a); 1: return 32'(rde_b); default: return 32'(rde_c); endcase
    endfunction
    function automatic logic [31:0] dut_rdd(int d);
        case (d) 0: return 32'(rdd_a); 1: return 32'(rdd_b); default: return 32'(rdd_c); endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            int lim = 1 << wid(d);
            if (rst) begin
                for (int ch = 0; ch < nch(d); ch++) begin
                    mc[d][ch] = ini(d);
                    mt[d][ch] = 0;
                end
                mrv[d] = 0; mre[d] = 0; mrd[d] = 0;
            end else begin
                int lch = int'(ldch_v[d]) % (1 << chb(d));
                int rch = int'(rch_v[d]) % (1 << chb(d));
                int old [3];
                for (int ch = 0; ch < 3; ch++) old[ch] = mc[d][ch];
                if (rq_v[d]) begin
                    mrv[d] = 1;
                    if (rch < nch(d)) begin
                        mrd[d] = old[rch]; mre[d] = 0;
                    end else begin
                        mrd[d] = 0; mre[d] = 1;
                    end
                end else begin
                    mrv[d] = 0; mre[d] = 0;
                end
                for (int ch = 0; ch < nch(d); ch++) begin
                    if (ld_v[d] && lch == ch) begin
                        mc[d][ch] = int'(ldval_v[d]) % lim;
                        mt[d][ch] = 0;
                    end else if (en_v[d][ch]) begin
                        if (!down(d, ch)) begin
                            int s = old[ch] + stp(d);
                            mt[d][ch] = (s >= lim);
                            mc[d][ch] = (s < lim) ? s : (sat(d, ch) ? lim - 1 : s - lim);
                        end else begin
                            mt[d][ch] = (old[ch] < stp(d));
                            mc[d][ch] = (old[ch] >= stp(d)) ? old[ch] - stp(d)
                                      : (sat(d, ch) ? 0 : old[ch] - stp(d) + lim);
                        end
                    end else begin
                        mt[d][ch] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            for (int ch = 0; ch < nch(d); ch++) begin
                chk($sformatf("d%0d_count%0d", d, ch), dut_cnt(d, ch), 32'(mc[d][ch]));
                chk($sformatf("d%0d_term%0d", d, ch), dut_term(d, ch), 32'(mt[d][ch]));
            end
            chk($sformatf("d%0d_rd_valid", d), dut_rdv(d), 32'(mrv[d]));
            chk($sformatf("d%0d_rd_err", d), dut_rde(d), 32'(mre[d]));
            chk($sformatf("d%0d_rd_data", d), dut_rdd(d), 32'(mrd[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            en_v[d] = '0; ld_v[d] = 1'b0; ldch_v[d] = '0; ldval_v[d] = '0;
            rq_v[d] = 1'b0; rch_v[d] = '0;
        end
    endtask

    initial begin
        idle();
        for (int d = 0; d < 3; d++) begin
            for (int ch = 0; ch < 3; ch++) begin mc[d][ch] = 0; mt[d][ch] = 0; end
            mrv[d] = 0; mrd[d] = 0; mre[d] = 0;
        end

        rst = 1'b1;
        tick();
        tick();
        chk("reset_c_init", dut_cnt(2, 0), 32'h4);
        rst = 1'b0;

        // Nine cycles of counting on both low channels of instance A.
        en_v[0] = 3'b011;
        repeat (9) tick();
        chk("up9_ch0", dut_cnt(0, 0), 32'h09);
        chk("down9_ch1", dut_cnt(0, 1), 32'hf7);

        // Wrap from fe through ff to 00.
        en_v[0] = 3'b000;
        ld_v[0] = 1'b1; ldch_v[0] = 2'd0; ldval_v[0] = 8'hfe;
        tick();
        ld_v[0] = 1'b0; en_v[0] = 3'b001;
        tick();
        chk("wrap_ff_term", dut_term(0, 0), 32'h0);
        tick();
        chk("wrap_00", dut_cnt(0, 0), 32'h00);
        chk("wrap_00_term", dut_term(0, 0), 32'h1);
        en_v[0] = 3'b000;

        // Saturating up channel on instance B held at the limit.
        ld_v[1] = 1'b1; ldch_v[1] = 2'd0; ldval_v[1] = 8'hfe;
        tick();
        ld_v[1] = 1'b0; en_v[1] = 3'b001;
        tick();
        chk("sat1_term", dut_term(1, 0), 32'h0);
        tick();
        chk("sat2_term", dut_term(1, 0), 32'h1);
        tick();
        chk("sat3_cnt", dut_cnt(1, 0), 32'hff);
        chk("sat3_term", dut_term(1, 0), 32'h1);
        en_v[1] = 3'b000;

        // Load on ch1 wins over its enable while ch0 still steps.
        ld_v[0] = 1'b1; ldch_v[0] = 2'd1; ldval_v[0] = 8'h05; en_v[0] = 3'b011;
        tick();
        chk("load_pri_ch1", dut_cnt(0, 1), 32'h05);
        chk("load_pri_term1", dut_term(0, 1), 32'h0);

        // Readout sees the value from before the edge's update.
        ld_v[0] = 1'b0; en_v[0] = 3'b010; rq_v[0] = 1'b1; rch_v[0] = 2'd1;
        tick();
        chk("rd_new_ch1", dut_cnt(0, 1), 32'h04);
        chk("rd_old_data", dut_rdd(0), 32'h05);
        en_v[0] = 3'b000; rch_v[0] = 2'd3;
        tick();
        chk("rd_oob_err", dut_rde(0), 32'h1);
        chk("rd_oob_data", dut_rdd(0), 32'h0);
        rq_v[0] = 1'b0;
        tick();
        chk("rd_idle_valid", dut_rdv(0), 32'h0);

        // Reset wins over enable and readout in the same cycle.
        en_v[0] = 3'b011; rq_v[0] = 1'b1; rch_v[0] = 2'd0; rst = 1'b1;
        tick();
        chk("rst_mid_valid", dut_rdv(0), 32'h0);
        chk("rst_mid_ch0", dut_cnt(0, 0), 32'h0);
        rst = 1'b0;
        idle();
        tick();

        // Randomised traffic across all instances.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 3; d++) begin
                en_v[d]    = 3'($urandom_range(0, 7));
                ld_v[d]    = ($urandom_range(0, 7) == 0);
                ldch_v[d]  = 2'($urandom_range(0, 3));
                ldval_v[d] = 8'($urandom);
                rq_v[d]    = 1'($urandom);
                rch_v[d]   = 2'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
